// File: rtl/cello_tt_pkg.sv
// Shared types and helpers for truth-table characterisation of small gates.
// Table bit ordering: input vector k maps to bit 2**n-1-k, so vector 0 is the MSB.
package cello_tt_pkg;

  typedef enum logic [1:0] {IDLE, APPLY, DONE} tt_state_e;

  function automatic int tt_bit_index(input int k, input int n);
    return (1 << n) - 1 - k;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: counts 0..SETTLE-1 while enabled and raises tc on the last count.
// Latency: tc is combinational from the count. Backpressure: none; load wins over en.
// The count wraps to zero on tc so consecutive vectors get equal hold times.
module tt_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt_q;

  assign tc = (cnt_q == CW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt_q <= '0;
    end else if (en) begin
      if (tc) cnt_q <= '0;
      else    cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a gate, captures its truth-table ID and compares to exp_id.
// Latency: done pulses 2**N_IN*SETTLE+1 cycles after start acceptance.
// Backpressure: none; start is ignored unless idle, and the result holds until the next start.
module truth_table_sweeper
  import cello_tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2**N_IN-1:0] exp_id,
  output logic [N_IN-1:0]    stim,
  input  logic               resp,
  output logic               busy,
  output logic               done,
  output logic [2**N_IN-1:0] table_id,
  output logic               match
);

  localparam int            W    = 2**N_IN;
  localparam logic [N_IN:0] LAST = (N_IN+1)'(W - 1);

  tt_state_e       state_q, state_d;
  logic [N_IN:0]   idx_q;
  logic [W-1:0]    table_q, table_d, exp_q;
  logic            match_q;
  logic            tc;
  logic            accept, last_vec;
  logic [N_IN-1:0] bit_pos;

  assign accept   = (state_q == IDLE) && start;
  assign last_vec = (state_q == APPLY) && tc && (idx_q == LAST);
  assign bit_pos  = N_IN'(tt_bit_index(int'(idx_q), N_IN));

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (state_q == APPLY),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (last_vec) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next table value including the bit sampled this cycle, so match sees the final bit.
  always_comb begin
    table_d = table_q;
    if ((state_q == APPLY) && tc) table_d[bit_pos] = resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      table_q <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      table_q <= '0;
      exp_q   <= exp_id;
      match_q <= 1'b0;
    end else if (state_q == APPLY) begin
      table_q <= table_d;
      if (tc && (idx_q != LAST)) idx_q <= idx_q + 1'b1;
      if (last_vec) match_q <= (table_d == exp_q);
    end
  end

  assign stim     = (state_q == APPLY) ? idx_q[N_IN-1:0] : '0;
  assign busy     = (state_q == APPLY);
  assign done     = (state_q == DONE);
  assign table_id = table_q;
  assign match    = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboarded bench: three sweeper configurations driven by modelled gates.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst   [3];
  logic       start [3];
  int         mode  [3];
  logic [7:0] exp_id0, exp_id1;
  logic [3:0] exp_id2;
  logic [2:0] stim0, stim1;
  logic [1:0] stim2;
  logic       resp0, resp1, resp2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [7:0] table0, table1;
  logic [3:0] table2;
  logic       match0, match1, match2;
  logic [7:0] g27 = 8'h27;

  int n_tests = 0;
  int n_fail  = 0;
  int lat [3] = '{17, 9, 13};

  typedef struct {
    int         cyc;
    logic [7:0] id;
    logic       m;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  // Gate models: 0 = 0x27 function, 1 = in3 buffer, 2 = in1 buffer, 3/4 = tied 1/0, 5 = AND of low two inputs
  function automatic logic gate(input int m, input logic [2:0] s);
    case (m)
      0:       gate = g27[~s];
      1:       gate = s[0];
      2:       gate = s[2];
      3:       gate = 1'b1;
      4:       gate = 1'b0;
      5:       gate = s[1] & s[0];
      default: gate = 1'b0;
    endcase
  endfunction

  assign resp0 = gate(mode[0], stim0);
  assign resp1 = gate(mode[1], stim1);
  assign resp2 = gate(mode[2], {1'b0, stim2});

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .exp_id(exp_id0), .stim(stim0), .resp(resp0),
    .busy(busy0), .done(done0), .table_id(table0), .match(match0)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .exp_id(exp_id1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .table_id(table1), .match(match1)
  );
  truth_table_sweeper #(.N_IN(2), .SETTLE(3)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .exp_id(exp_id2), .stim(stim2), .resp(resp2),
    .busy(busy2), .done(done2), .table_id(table2), .match(match2)
  );

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int d, input int c, input logic [7:0] id, input logic m);
    exp_t e;
    e.cyc = c;
    e.id  = id;
    e.m   = m;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Issue a one-cycle start on instance d and queue the expected result.
  task automatic sweep(input int d, input int md, input logic [7:0] e,
                       input logic [7:0] id, input logic m);
    @(negedge clk);
    mode[d] = md;
    case (d)
      0:       exp_id0 = e;
      1:       exp_id1 = e;
      default: exp_id2 = e[3:0];
    endcase
    start[d] = 1'b1;
    push(d, cyc + lat[d], id, m);
    @(negedge clk);
    start[d] = 1'b0;
    repeat (lat[d] + 1) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) check("u0 unexpected done", 1, 0);
      else begin
        e = q0.pop_front();
        check("u0 done cycle", cyc, e.cyc);
        check("u0 table_id", int'(table0), int'(e.id));
        check("u0 match", int'(match0), int'(e.m));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("u1 unexpected done", 1, 0);
      else begin
        e = q1.pop_front();
        check("u1 done cycle", cyc, e.cyc);
        check("u1 table_id", int'(table1), int'(e.id));
        check("u1 match", int'(match1), int'(e.m));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) check("u2 unexpected done", 1, 0);
      else begin
        e = q2.pop_front();
        check("u2 done cycle", cyc, e.cyc);
        check("u2 table_id", int'(table2), int'(e.id[3:0]));
        check("u2 match", int'(match2), int'(e.m));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    int bcount;
    for (int i = 0; i < 3; i++) begin
      rst[i]   = 1'b1;
      start[i] = 1'b0;
      mode[i]  = 0;
    end
    exp_id0 = 8'h00;
    exp_id1 = 8'h00;
    exp_id2 = 4'h0;
    repeat (3) @(negedge clk);
    check("reset stim", int'(stim0), 0);
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    check("reset match", int'(match0), 0);
    check("reset table_id", int'(table0), 0);
    check("reset u2 table_id", int'(table2), 0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);

    // 0x27 gate with busy window check
    mode[0] = 0;
    exp_id0 = 8'h27;
    check("busy before start", int'(busy0), 0);
    start[0] = 1'b1;
    c = cyc;
    push(0, c + 17, 8'h27, 1'b1);
    bcount = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (busy0) bcount++;
      if (k == 1)  check("busy first cycle", int'(busy0), 1);
      if (k == 16) check("busy last cycle", int'(busy0), 1);
      if (k == 17) check("busy at done", int'(busy0), 0);
    end
    check("busy cycle count", bcount, 16);
    repeat (2) @(negedge clk);

    sweep(0, 1, 8'h27, 8'h55, 1'b0);
    sweep(0, 2, 8'h27, 8'h0F, 1'b0);

    // Reset in the middle of a sweep
    mode[0] = 0;
    exp_id0 = 8'h27;
    start[0] = 1'b1;
    c = cyc;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < c + 7) @(negedge clk);
    check("mid-sweep busy", int'(busy0), 1);
    check("mid-sweep stim", int'(stim0), 3);
    check("mid-sweep partial table", int'(table0), 8'h20);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("post-rst stim", int'(stim0), 0);
    check("post-rst busy", int'(busy0), 0);
    check("post-rst table_id", int'(table0), 0);
    check("post-rst done", int'(done0), 0);
    repeat (20) @(negedge clk);
    sweep(0, 0, 8'h27, 8'h27, 1'b1);

    // Start re-pulsed during a sweep must be ignored
    mode[0] = 2;
    exp_id0 = 8'h0F;
    start[0] = 1'b1;
    c = cyc;
    push(0, c + 17, 8'h0F, 1'b1);
    while (cyc < c + 22) begin
      @(negedge clk);
      start[0] = (cyc == c + 3) || (cyc == c + 10);
    end

    // Start held high: back-to-back sweeps
    mode[0] = 0;
    exp_id0 = 8'h27;
    start[0] = 1'b1;
    c = cyc;
    push(0, c + 17, 8'h27, 1'b1);
    push(0, c + 35, 8'h27, 1'b1);
    while (cyc < c + 19) @(negedge clk);
    start[0] = 1'b0;
    while (cyc < c + 40) @(negedge clk);

    // SETTLE = 1: stim walks 0..7 one cycle each
    mode[1] = 3;
    exp_id1 = 8'hFF;
    start[1] = 1'b1;
    c = cyc;
    push(1, c + 9, 8'hFF, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start[1] = 1'b0;
      check($sformatf("u1 stim step %0d", k), int'(stim1), k - 1);
    end
    repeat (3) @(negedge clk);
    sweep(1, 4, 8'h27, 8'h00, 1'b0);

    // N_IN = 2, SETTLE = 3, AND gate
    sweep(2, 5, 8'h01, 8'h01, 1'b1);

    repeat (5) @(negedge clk);
    check("u0 scoreboard drained", q0.size(), 0);
    check("u1 scoreboard drained", q1.size(), 0);
    check("u2 scoreboard drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
